truth_table_capture: RTL
========================

// Module: truth_table_capture
// PURPOSE
//  Response-side companion to the combinational exercise blocks (PoS/SoP). Sweeps all 2^N_IN
//  input vectors into a DUT, samples its 1-bit output, and assembles the captured truth table.
//  Reports the minterm count, a mismatch mask against an expected table, and pass/fail.
//  Sits between a free-running clock domain and any purely combinational N_IN-input function.
// PARAMETERS
//  N_IN      4        number of DUT inputs; the table has 2^N_IN entries
//  SETTLE    1        idle cycles between driving a vector and sampling s_in (0..15)
//  EXPECTED  16'hD0C4 expected table, bit i = f(i); default is (a+c)(c+d')(a'+b)(b+d'), {a,b,c,d}=i
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         asynchronous, active-low reset
//  start          in   1         begin sweep; honoured only in IDLE
//  abort          in   1         cancel sweep; return to IDLE
//  s_in           in   1         DUT output under test
//  vec_out        out  N_IN      vector driven to DUT, MSB = a
//  busy           out  1         high from the cycle after start until done
//  done           out  1         one-cycle pulse when the sweep completes
//  valid          out  1         results below are complete and stable
//  truth_table    out  2^N_IN    captured table, bit i = s_in sampled for vector i
//  ones_count     out  N_IN+1    number of 1s in truth_table (minterm count)
//  mismatch_mask  out  2^N_IN    truth_table ^ EXPECTED
//  pass           out  1         valid && mismatch_mask == 0
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; vec_out=0, busy=0, done=0, valid=0,
//   truth_table=0, ones_count=0, mismatch_mask=0, pass=0.
//  FSM: IDLE -> DRIVE -> WAIT -> SAMPLE -> (DRIVE | FINISH) -> IDLE.
//   IDLE: start=1 -> DRIVE; idx=0; valid cleared; truth_table cleared.
//   DRIVE: vec_out=idx; settle counter = SETTLE; -> WAIT, or -> SAMPLE if SETTLE=0.
//   WAIT: the counter decrements once per cycle; -> SAMPLE when it reaches 1.
//   SAMPLE: truth_table[idx] <= s_in. If idx==2^N_IN-1 -> FINISH, else idx+1 -> DRIVE.
//   FINISH: ones_count, mismatch_mask and pass are registered; valid=1; done=1 for one cycle;
//    -> IDLE.
//  Timing: each vector holds vec_out for SETTLE+2 cycles.
//   Start-accept edge to done pulse = 2^N_IN*(SETTLE+2)+1 cycles.
//  vec_out holds its last value in IDLE. Results hold until the next accepted start.
//  start while busy: ignored.
//  abort (any non-IDLE state): -> IDLE next edge; busy=0; valid=0; no done pulse.
//   abort has priority over start and over SAMPLE in the same cycle.
//  start and abort together in IDLE: abort wins; the sweep does not start.
//  idx counter is N_IN bits wide; its wrap is never used because FINISH is taken at the max
//   value.
//  ones_count width N_IN+1 holds 2^N_IN without overflow.
//  rst_n low mid-sweep: immediate return to reset values; the partial table is discarded.
// STRUCTURE
//  Shared include tt_defs.vh: FSM state localparams (IDLE, DRIVE, WAIT, SAMPLE, FINISH;
//   3-bit encoding).
//  Sub-module popcount #(W) (comb, W-bit in -> $clog2(W)+1-bit out) computes ones_count.
//  Top: FSM, idx counter, settle counter, capture register, result registers.
// TESTING
//  1 Default params, DUT = PoS function; pulse start -> done after 49 cycles;
//    truth_table=16'hD0C4, ones_count=6, pass=1.
//  2 DUT s_in tied 1 -> truth_table=16'hFFFF, ones_count=16, mismatch_mask=16'h2F3B, pass=0.
//  3 SETTLE=0, DUT = a&b&c&d -> done 33 cycles after start; truth_table=16'h8000,
//    ones_count=1.
//  4 abort asserted while vector 5 is driven -> busy=0 next cycle, valid=0, no done;
//    a new start then performs a full sweep.
//  5 start re-pulsed mid-sweep -> ignored; done still at cycle 49; vec_out sequence 0..15
//    unbroken.
//  6 rst_n pulled low at vector 9 -> all outputs at reset values asynchronously;
//    start after release -> correct result.

Source files
------------

// File: rtl/truth_table_capture_pkg.sv
// rtl/truth_table_capture_pkg.sv - shared types and constants for the truth-table capture block
// Purpose: FSM state encoding and the settle-counter width used by truth_table_capture.
// Ports: none (package).
package truth_table_capture_pkg;

  // Width of the settle counter; SETTLE is limited to 0..15.
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/truth_table_capture_if.sv
// rtl/truth_table_capture_if.sv - control and result bundle of the truth-table capture block
// Purpose: groups sweep control, DUT stimulus/response and captured results.
// Ports (signals):
//   start, abort     sweep control from the requester
//   s_in             response of the function under test
//   vec_out          vector driven to the function under test, MSB = a
//   busy, done       sweep status / one-cycle completion pulse
//   valid            results complete and stable
//   truth_table      captured table, bit i = response to vector i
//   ones_count       minterm count of truth_table
//   mismatch_mask    truth_table ^ expected table
//   pass             valid && mismatch_mask == 0
// Modports: master = requester / test side, slave = capture block.
interface truth_table_capture_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic                   abort;
  logic                   s_in;
  logic [N_IN-1:0]        vec_out;
  logic                   busy;
  logic                   done;
  logic                   valid;
  logic [(1<<N_IN)-1:0]   truth_table;
  logic [N_IN:0]          ones_count;
  logic [(1<<N_IN)-1:0]   mismatch_mask;
  logic                   pass;

  modport master (
    output start, abort, s_in,
    input  vec_out, busy, done, valid, truth_table, ones_count, mismatch_mask, pass
  );

  modport slave (
    input  start, abort, s_in,
    output vec_out, busy, done, valid, truth_table, ones_count, mismatch_mask, pass
  );
endinterface

// File: rtl/truth_table_capture_popcount.sv
// rtl/truth_table_capture_popcount.sv - combinational population count
// Purpose: counts the set bits of a W-bit word.
// Ports:
//   in_i     in   W              word to count
//   count_o  out  $clog2(W)+1    number of ones in in_i
module truth_table_capture_popcount #(
  parameter int W = 16
) (
  input  logic [W-1:0]         in_i,
  output logic [$clog2(W):0]   count_o
);
  localparam int CW = $clog2(W) + 1;

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(in_i[i]);
    end
  end
endmodule

// File: rtl/truth_table_capture.sv
// rtl/truth_table_capture.sv - sweeps all input vectors of a combinational function and captures its table
// Purpose: drives every N_IN-bit vector in turn, samples the 1-bit response after SETTLE idle
//   cycles, then reports the captured table, its minterm count, a mismatch mask against
//   EXPECTED and pass/fail.
// Ports:
//   clk_i    in   1   rising-edge clock
//   rst_ni   in   1   asynchronous active-low reset
//   bus      slave modport of truth_table_capture_if (control, stimulus, response, results)
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int                   N_IN     = 4,
  parameter int                   SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'hD0C4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  truth_table_capture_if.slave  bus
);
  localparam int TW = 1 << N_IN;

  state_e                state_q, state_d;
  logic [N_IN-1:0]       idx_q, idx_d;
  logic [SETTLE_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]         tt_q, tt_d;
  logic [N_IN:0]         ones_q, ones_d;
  logic [TW-1:0]         mm_q, mm_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [N_IN:0]         pop_count;

  truth_table_capture_popcount #(.W(TW)) u_popcount (
    .in_i    (tt_q),
    .count_o (pop_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      mm_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      mm_q    <= mm_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    mm_d    = mm_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    // abort outranks start and the capture in SAMPLE; in IDLE it also suppresses start.
    if (bus.abort) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_DRIVE;
            idx_d   = '0;
            tt_d    = '0;
            ones_d  = '0;
            mm_d    = '0;
            valid_d = 1'b0;
          end
        end
        ST_DRIVE: begin
          cnt_d   = SETTLE_W'(SETTLE);
          state_d = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
        end
        ST_WAIT: begin
          // Leaving at a count of 1 gives exactly SETTLE cycles in WAIT.
          if (cnt_q <= SETTLE_W'(1)) begin
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
        ST_SAMPLE: begin
          tt_d[idx_q] = bus.s_in;
          if (idx_q == {N_IN{1'b1}}) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + N_IN'(1);
            state_d = ST_DRIVE;
          end
        end
        ST_FINISH: begin
          ones_d  = pop_count;
          mm_d    = tt_q ^ EXPECTED;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // The vector index doubles as the stimulus, so vec_out changes on entry to DRIVE and
  // holds through WAIT and SAMPLE, and keeps its last value while idle.
  assign bus.vec_out       = idx_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = done_q;
  assign bus.valid         = valid_q;
  assign bus.truth_table   = tt_q;
  assign bus.ones_count    = ones_q;
  assign bus.mismatch_mask = mm_q;
  assign bus.pass          = valid_q && (mm_q == '0);
endmodule
